bp_me_manycore_rev_assembler: RTL and testbench

Response-side bridge for the unicore HammerBlade build. It collects HammerBlade manycore return packets (32-bit load data or store acks, possibly out of order) for the single outstanding BedRock memory command. It then emits the matching BedRock mem_rev header plus 64-bit fill beats back to the BlackParrot core. It is the return-path counterpart of the BedRock-to-manycore command converter, which hands it the stashed response header.

---
 rtl/bp_hb_pkg.sv | 60 ++++++
 rtl/bp_me_manycore_word_buffer.sv | 53 +++++
 rtl/bp_me_manycore_rev_assembler.sv | 188 ++++++++++++++++++
 tb/tb_bp_me_manycore_rev_assembler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_hb_pkg.sv
// Shared types and helpers for the HammerBlade manycore <-> BedRock bridge.
package bp_hb_pkg;

    // Supported BlackParrot build configurations
    typedef enum logic [3:0] {
        e_bp_unicore_hammerblade_cfg = 4'd0
    } bp_params_e;

    localparam int paddr_width_lp         = 40;
    localparam int bedrock_fill_width_lp  = 64;
    localparam int bedrock_block_width_lp = 512;

    // Manycore return packet kinds
    typedef enum logic [1:0] {
        e_hb_return_load   = 2'd0,
        e_hb_return_store  = 2'd1,
        e_hb_return_credit = 2'd2
    } bp_hb_return_pkt_type_e;

    // BedRock memory message types
    localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
    localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
    localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

    typedef struct packed {
        logic [3:0]                msg_type;
        logic [paddr_width_lp-1:0] addr;
        logic [2:0]                size;
        logic [15:0]               payload;
    } bp_bedrock_mem_rev_header_s;

    // Fill width selected by the build configuration
    function automatic int bp_fill_width(input bp_params_e cfg);
        case (cfg)
            e_bp_unicore_hammerblade_cfg: return bedrock_fill_width_lp;
            default:                      return bedrock_fill_width_lp;
        endcase
    endfunction

    // 32-bit words covered by a request of size encoding s (1B..64B)
    function automatic logic [4:0] hb_word_count(input logic [2:0] size);
        logic [2:0] s;
        s = (size > 3'd6) ? 3'd6 : size;
        return (s <= 3'd2) ? 5'd1 : (5'd1 << (s - 3'd2));
    endfunction

    // 64-bit fill beats covered by a request of size encoding s
    function automatic logic [3:0] hb_beat_count(input logic [2:0] size);
        logic [2:0] s;
        s = (size > 3'd6) ? 3'd6 : size;
        return (s <= 3'd3) ? 4'd1 : (4'd1 << (s - 3'd3));
    endfunction

    // Writes return a single zero-data beat regardless of size
    function automatic logic hb_is_store(input logic [3:0] msg_type);
        return (msg_type == e_bedrock_mem_wr) || (msg_type == e_bedrock_mem_uc_wr);
    endfunction

endpackage

// File: rtl/bp_me_manycore_word_buffer.sv
// Word register file with per-entry valid bits; read port returns the
// word pair that forms one 64-bit fill beat.
module bp_me_manycore_word_buffer #(
    parameter int  word_width_p = 32,
    parameter int  max_words_p  = 16,
    localparam int idx_w_lp     = $clog2(max_words_p),
    localparam int beat_w_lp    = $clog2(max_words_p / 2)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clear_i,
    input  logic                      w_v_i,
    input  logic [idx_w_lp-1:0]       w_idx_i,
    input  logic [word_width_p-1:0]   w_data_i,
    input  logic [beat_w_lp-1:0]      rd_beat_i,
    output logic [2*word_width_p-1:0] rd_data_o,
    output logic [max_words_p-1:0]    valid_o
);

    logic [max_words_p-1:0][word_width_p-1:0] mem_q, mem_d;
    logic [max_words_p-1:0]                   valid_q, valid_d;

    // Next-state: clear drops all valid bits, write fills one entry
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end
        if (w_v_i) begin
            mem_d[w_idx_i]   = w_data_i;
            valid_d[w_idx_i] = 1'b1;
        end
    end

    // Valid bits are reset; data is only meaningful where valid
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data storage, no reset needed
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rd_data_o = {mem_q[{rd_beat_i, 1'b1}], mem_q[{rd_beat_i, 1'b0}]};
    assign valid_o   = valid_q;

endmodule

// File: rtl/bp_me_manycore_rev_assembler.sv
// Collects manycore return packets for the single outstanding BedRock
// command and replays them as a mem_rev header plus 64-bit fill beats.
//
// Handshakes: a transfer happens on any cycle where valid and ready are
// both high at the clock edge. Header in: mem_rev_header_v_i and
// mem_rev_header_ready_and_o. Returns: returned_yumi_o is asserted only
// when returned_v_i is already high, meaning the packet is taken this cycle.
// Beats out: mem_rev_v_o with mem_rev_ready_and_i; while ready is low the
// header, data and last outputs stay stable.
module bp_me_manycore_rev_assembler
    import bp_hb_pkg::*;
#(
    parameter bp_params_e bp_params_p    = e_bp_unicore_hammerblade_cfg,
    parameter int         word_width_p   = 32,
    parameter int         max_words_p    = bedrock_block_width_lp / word_width_p,
    parameter int         reg_id_width_p = 5,
    localparam int        fill_width_lp  = bp_fill_width(bp_params_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  bp_bedrock_mem_rev_header_s mem_rev_header_i,
    input  logic                       mem_rev_header_v_i,
    output logic                       mem_rev_header_ready_and_o,
    input  logic                       returned_v_i,
    input  logic [1:0]                 returned_pkt_type_i,
    input  logic [word_width_p-1:0]    returned_data_i,
    input  logic [reg_id_width_p-1:0]  returned_reg_id_i,
    output logic                       returned_yumi_o,
    output bp_bedrock_mem_rev_header_s mem_rev_header_o,
    output logic [fill_width_lp-1:0]   mem_rev_data_o,
    output logic                       mem_rev_v_o,
    output logic                       mem_rev_last_o,
    input  logic                       mem_rev_ready_and_i
);

    localparam int idx_w_lp  = $clog2(max_words_p);
    localparam int cnt_w_lp  = $clog2(max_words_p) + 1;
    localparam int beat_w_lp = $clog2(max_words_p / 2);

    localparam logic [1:0] e_idle    = 2'd0;
    localparam logic [1:0] e_collect = 2'd1;
    localparam logic [1:0] e_send    = 2'd2;

    logic [1:0]                 state_q, state_d;
    bp_bedrock_mem_rev_header_s header_q, header_d;
    logic [cnt_w_lp-1:0]        words_q, words_d;
    logic [cnt_w_lp-1:0]        rx_cnt_q, rx_cnt_d;
    logic [beat_w_lp-1:0]       beat_q, beat_d;
    logic [beat_w_lp-1:0]       last_beat_q, last_beat_d;
    logic                       store_q, store_d;

    logic                       buf_clear;
    logic                       buf_w_v;
    logic [2*word_width_p-1:0]  buf_rd_data;
    logic [max_words_p-1:0]     buf_valid;

    logic                       pkt_load;
    logic                       pkt_store;
    logic                       in_range;
    logic                       dup;

    assign pkt_load  = (returned_pkt_type_i == e_hb_return_load);
    assign pkt_store = (returned_pkt_type_i == e_hb_return_store);
    assign in_range  = (32'(returned_reg_id_i) < 32'(words_q));
    assign dup       = buf_valid[returned_reg_id_i[idx_w_lp-1:0]];

    bp_me_manycore_word_buffer #(
        .word_width_p (word_width_p),
        .max_words_p  (max_words_p)
    ) word_buffer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (buf_clear),
        .w_v_i     (buf_w_v),
        .w_idx_i   (returned_reg_id_i[idx_w_lp-1:0]),
        .w_data_i  (returned_data_i),
        .rd_beat_i (beat_q),
        .rd_data_o (buf_rd_data),
        .valid_o   (buf_valid)
    );

    // Transaction FSM: accept header, count returns, stream beats
    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        words_d     = words_q;
        rx_cnt_d    = rx_cnt_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        store_d     = store_q;
        buf_clear   = 1'b0;
        buf_w_v     = 1'b0;

        mem_rev_header_ready_and_o = 1'b0;
        returned_yumi_o            = 1'b0;
        mem_rev_v_o                = 1'b0;

        case (state_q)
            e_idle: begin
                mem_rev_header_ready_and_o = 1'b1;
                if (mem_rev_header_v_i) begin
                    header_d    = mem_rev_header_i;
                    words_d     = cnt_w_lp'(hb_word_count(mem_rev_header_i.size));
                    store_d     = hb_is_store(mem_rev_header_i.msg_type);
                    last_beat_d = store_d ? '0
                                          : beat_w_lp'(hb_beat_count(mem_rev_header_i.size) - 4'd1);
                    rx_cnt_d    = '0;
                    beat_d      = '0;
                    buf_clear   = 1'b1;
                    state_d     = e_collect;
                end
            end
            e_collect: begin
                returned_yumi_o = returned_v_i;
                if (returned_v_i) begin
                    // Out-of-range or duplicate returns are consumed and dropped
                    if (pkt_load && in_range && !dup) begin
                        buf_w_v  = 1'b1;
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end else if (pkt_store && in_range) begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                if (rx_cnt_d == words_q) begin
                    state_d = e_send;
                end
            end
            e_send: begin
                mem_rev_v_o = 1'b1;
                if (mem_rev_ready_and_i) begin
                    if (beat_q == last_beat_q) begin
                        beat_d  = '0;
                        state_d = e_idle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // State registers; reset abandons any partial transaction
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            header_q    <= '0;
            words_q     <= '0;
            rx_cnt_q    <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            store_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            words_q     <= words_d;
            rx_cnt_q    <= rx_cnt_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            store_q     <= store_d;
        end
    end

    // Sub-word loads are replicated across the beat; writes return zeros
    always_comb begin
        if (store_q) begin
            mem_rev_data_o = '0;
        end else if (words_q == cnt_w_lp'(1)) begin
            mem_rev_data_o = {2{buf_rd_data[word_width_p-1:0]}};
        end else begin
            mem_rev_data_o = buf_rd_data;
        end
    end

    assign mem_rev_header_o = header_q;
    assign mem_rev_last_o   = (beat_q == last_beat_q);

`ifndef SYNTHESIS
    // Flag malformed returns; the datapath drops them regardless
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_q == e_collect && returned_v_i) begin
            assert (!(pkt_load || pkt_store) || in_range);
            assert (!(pkt_load && in_range && dup));
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_manycore_rev_assembler.sv
// Bench for the manycore return assembler: directed table, hand-written
// reset sequence, and randomized transactions against a behavioural model.
module tb_bp_me_manycore_rev_assembler;
  import bp_hb_pkg::*;

  typedef bp_bedrock_mem_rev_header_s hdr_t;

  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  id;
    logic [31:0] data;
  } pkt_t;

  typedef struct {
    logic [2:0]  size;
    logic [3:0]  msg;
    int          order;
    int          n_credit;
    int          stall;
    logic [31:0] base;
    int          exp_nbeats;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        reset_i;
  hdr_t        mem_rev_header_i;
  logic        mem_rev_header_v_i;
  logic        mem_rev_header_ready_and_o;
  logic        returned_v_i;
  logic [1:0]  returned_pkt_type_i;
  logic [31:0] returned_data_i;
  logic [4:0]  returned_reg_id_i;
  logic        returned_yumi_o;
  hdr_t        mem_rev_header_o;
  logic [63:0] mem_rev_data_o;
  logic        mem_rev_v_o;
  logic        mem_rev_last_o;
  logic        mem_rev_ready_and_i;

  always #5 clk_i = ~clk_i;

  bp_me_manycore_rev_assembler dut (
    .clk_i                      (clk_i),
    .reset_i                    (reset_i),
    .mem_rev_header_i           (mem_rev_header_i),
    .mem_rev_header_v_i         (mem_rev_header_v_i),
    .mem_rev_header_ready_and_o (mem_rev_header_ready_and_o),
    .returned_v_i               (returned_v_i),
    .returned_pkt_type_i        (returned_pkt_type_i),
    .returned_data_i            (returned_data_i),
    .returned_reg_id_i          (returned_reg_id_i),
    .returned_yumi_o            (returned_yumi_o),
    .mem_rev_header_o           (mem_rev_header_o),
    .mem_rev_data_o             (mem_rev_data_o),
    .mem_rev_v_o                (mem_rev_v_o),
    .mem_rev_last_o             (mem_rev_last_o),
    .mem_rev_ready_and_i        (mem_rev_ready_and_i)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  pkt_t        pkt_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  vec_t        vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_words(input logic [2:0] size);
    int s;
    s = int'(size);
    return (s <= 2) ? 1 : (1 << (s - 2));
  endfunction

  function automatic bit model_store(input logic [3:0] msg);
    return (msg == e_bedrock_mem_wr) || (msg == e_bedrock_mem_uc_wr);
  endfunction

  // Expected beats from the returned words and the request header
  task automatic model_expect(input hdr_t hdr);
    logic [31:0] words [16];
    int w, nb, s;
    bit st;
    for (int i = 0; i < 16; i++) words[i] = 32'h0;
    s  = int'(hdr.size);
    w  = model_words(hdr.size);
    st = model_store(hdr.msg_type);
    nb = st ? 1 : ((s <= 3) ? 1 : (1 << (s - 3)));
    foreach (pkt_q[i]) begin
      if (pkt_q[i].typ == 2'd0) words[pkt_q[i].id] = pkt_q[i].data;
    end
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      if (st) exp_q.push_back(64'h0);
      else if (w == 1) exp_q.push_back({words[0], words[0]});
      else exp_q.push_back({words[2*b+1], words[2*b]});
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic hdr_t make_hdr(input logic [2:0] size, input logic [3:0] msg);
    hdr_t h;
    logic [63:0] a;
    a = {$urandom, $urandom};
    h.msg_type = msg;
    h.size     = size;
    h.addr     = a[39:0];
    h.payload  = 16'($urandom_range(0, 65535));
    return h;
  endfunction

  // order: 0 ascending, 1 descending, 2 shuffled. Credits never land last.
  task automatic gen_pkts(input logic [2:0] size, input logic [3:0] msg, input int order,
                          input int n_credit, input logic [31:0] base);
    int ids[$];
    int w, j, tmp, pos;
    pkt_t p;
    pkt_q.delete();
    w = model_words(size);
    for (int i = 0; i < w; i++) begin
      if (order == 1) ids.push_front(i);
      else ids.push_back(i);
    end
    if (order == 2) begin
      for (int i = w - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = ids[i]; ids[i] = ids[j]; ids[j] = tmp;
      end
    end
    foreach (ids[i]) begin
      p.typ  = model_store(msg) ? 2'd1 : 2'd0;
      p.id   = 5'(ids[i]);
      p.data = base + 32'(ids[i]);
      pkt_q.push_back(p);
    end
    for (int c = 0; c < n_credit; c++) begin
      p.typ  = 2'd2;
      p.id   = 5'($urandom_range(0, 31));
      p.data = $urandom;
      pos = $urandom_range(0, pkt_q.size() - 1);
      pkt_q.insert(pos, p);
    end
  endtask

  // One full transaction: header, returns from pkt_q, optional stall, beats
  task automatic run_txn(input hdr_t hdr, input int stall_cycles, input bit rand_ready);
    int n, beat, nexp;
    bit done;
    logic [63:0] hold_d, exp_d;
    logic hold_l;
    got_q.delete();
    model_expect(hdr);
    nexp = exp_q.size();

    n = 0;
    while (mem_rev_header_ready_and_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("hdr_ready_idle", 64'(mem_rev_header_ready_and_o), 64'd1);
    mem_rev_header_i   = hdr;
    mem_rev_header_v_i = 1'b1;
    @(negedge clk_i);
    mem_rev_header_v_i = 1'b0;
    check("hdr_ready_collect", 64'(mem_rev_header_ready_and_o), 64'd0);

    foreach (pkt_q[i]) begin
      returned_v_i        = 1'b1;
      returned_pkt_type_i = pkt_q[i].typ;
      returned_reg_id_i   = pkt_q[i].id;
      returned_data_i     = pkt_q[i].data;
      #1;
      check("yumi_collect", 64'(returned_yumi_o), 64'd1);
      check("v_during_collect", 64'(mem_rev_v_o), 64'd0);
      @(negedge clk_i);
    end
    returned_v_i = 1'b0;
    check("first_beat_latency", 64'(mem_rev_v_o), 64'd1);

    hold_d = mem_rev_data_o;
    hold_l = mem_rev_last_o;
    mem_rev_ready_and_i = 1'b0;
    for (int s = 0; s < stall_cycles; s++) begin
      returned_v_i        = 1'b1;
      returned_pkt_type_i = 2'd2;
      @(negedge clk_i);
      check("stall_v", 64'(mem_rev_v_o), 64'd1);
      check("stall_data", mem_rev_data_o, hold_d);
      check("stall_last", 64'(mem_rev_last_o), 64'(hold_l));
      check("stall_hdr", 64'(mem_rev_header_o), 64'(hdr));
      check("stall_yumi", 64'(returned_yumi_o), 64'd0);
      check("stall_hdr_ready", 64'(mem_rev_header_ready_and_o), 64'd0);
    end
    returned_v_i = 1'b0;

    beat = 0;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      mem_rev_ready_and_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (mem_rev_v_o && mem_rev_ready_and_i) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_beat");
        end else begin
          exp_d = exp_q.pop_front();
          check("beat_data", mem_rev_data_o, exp_d);
        end
        check("beat_last", 64'(mem_rev_last_o), 64'(beat == nexp - 1));
        check("beat_hdr", 64'(mem_rev_header_o), 64'(hdr));
        got_q.push_back(mem_rev_data_o);
        if (mem_rev_last_o) done = 1'b1;
        beat++;
      end
      @(negedge clk_i);
      n++;
    end
    mem_rev_ready_and_i = 1'b0;
    if (!done) fail_now("last_beat_timeout");
    check("beat_count", 64'(beat), 64'(nexp));
    check("v_after_last", 64'(mem_rev_v_o), 64'd0);
    check("hdr_ready_after", 64'(mem_rev_header_ready_and_o), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    hdr_t h;
    logic [3:0] msgs [4];
    msgs[0] = e_bedrock_mem_rd;
    msgs[1] = e_bedrock_mem_wr;
    msgs[2] = e_bedrock_mem_uc_rd;
    msgs[3] = e_bedrock_mem_uc_wr;

    //          size  msg                  ord cr st base          nb first                  last
    vecs[0] = '{3'd6, e_bedrock_mem_rd,    0, 0, 0, 32'h1000,     8, 64'h00001001_00001000, 64'h0000100F_0000100E};
    vecs[1] = '{3'd6, e_bedrock_mem_rd,    1, 0, 0, 32'h1000,     8, 64'h00001001_00001000, 64'h0000100F_0000100E};
    vecs[2] = '{3'd2, e_bedrock_mem_rd,    0, 0, 0, 32'hDEADBEEF, 1, 64'hDEADBEEF_DEADBEEF, 64'hDEADBEEF_DEADBEEF};
    vecs[3] = '{3'd6, e_bedrock_mem_wr,    0, 3, 0, 32'h4000,     1, 64'h0,                 64'h0};
    vecs[4] = '{3'd3, e_bedrock_mem_rd,    0, 0, 5, 32'h50,       1, 64'h00000051_00000050, 64'h00000051_00000050};
    vecs[5] = '{3'd5, e_bedrock_mem_uc_rd, 2, 2, 0, 32'h300,      4, 64'h00000301_00000300, 64'h00000307_00000306};
    vecs[6] = '{3'd0, e_bedrock_mem_uc_rd, 0, 0, 0, 32'h77,       1, 64'h00000077_00000077, 64'h00000077_00000077};
    vecs[7] = '{3'd3, e_bedrock_mem_uc_wr, 1, 1, 0, 32'h9,        1, 64'h0,                 64'h0};
    vecs[8] = '{3'd4, e_bedrock_mem_rd,    2, 0, 2, 32'h200,      2, 64'h00000201_00000200, 64'h00000203_00000202};

    reset_i             = 1'b1;
    mem_rev_header_i    = '0;
    mem_rev_header_v_i  = 1'b0;
    returned_v_i        = 1'b0;
    returned_pkt_type_i = 2'd0;
    returned_data_i     = 32'h0;
    returned_reg_id_i   = 5'd0;
    mem_rev_ready_and_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;

    // reset state: ready to take a header, nothing emitted or consumed
    returned_v_i = 1'b1;
    #1;
    check("rst_hdr_ready", 64'(mem_rev_header_ready_and_o), 64'd1);
    check("rst_yumi", 64'(returned_yumi_o), 64'd0);
    check("rst_v", 64'(mem_rev_v_o), 64'd0);
    returned_v_i = 1'b0;
    @(negedge clk_i);

    // directed table
    for (int k = 0; k < 9; k++) begin
      h = make_hdr(vecs[k].size, vecs[k].msg);
      gen_pkts(vecs[k].size, vecs[k].msg, vecs[k].order, vecs[k].n_credit, vecs[k].base);
      run_txn(h, vecs[k].stall, 1'b0);
      check($sformatf("vec%0d_nbeats", k), 64'(got_q.size()), 64'(vecs[k].exp_nbeats));
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_first", k), got_q[0], vecs[k].exp_first);
        check($sformatf("vec%0d_last", k), got_q[got_q.size()-1], vecs[k].exp_last);
      end else begin
        fail_now($sformatf("vec%0d_no_beats", k));
      end
    end

    // reset in the middle of collection, then a fresh 8B load
    h = make_hdr(3'd6, e_bedrock_mem_rd);
    mem_rev_header_i   = h;
    mem_rev_header_v_i = 1'b1;
    @(negedge clk_i);
    mem_rev_header_v_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      returned_v_i        = 1'b1;
      returned_pkt_type_i = 2'd0;
      returned_reg_id_i   = 5'(i);
      returned_data_i     = 32'h900 + 32'(i);
      @(negedge clk_i);
    end
    returned_v_i = 1'b0;
    reset_i      = 1'b1;
    @(negedge clk_i);
    reset_i             = 1'b0;
    returned_v_i        = 1'b1;
    returned_pkt_type_i = 2'd0;
    returned_reg_id_i   = 5'd0;
    #1;
    check("midrst_yumi", 64'(returned_yumi_o), 64'd0);
    check("midrst_v", 64'(mem_rev_v_o), 64'd0);
    check("midrst_hdr_ready", 64'(mem_rev_header_ready_and_o), 64'd1);
    returned_v_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("midrst_no_stale_beat", 64'(mem_rev_v_o), 64'd0);
    end
    h = make_hdr(3'd3, e_bedrock_mem_rd);
    gen_pkts(3'd3, e_bedrock_mem_rd, 0, 0, 32'hA);
    run_txn(h, 0, 1'b0);
    check("midrst_nbeats", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("midrst_beat", got_q[0], 64'h0000000B_0000000A);

    // randomized transactions against the model
    for (int r = 0; r < 25; r++) begin
      logic [2:0] sz;
      logic [3:0] mg;
      sz = 3'($urandom_range(0, 6));
      mg = msgs[$urandom_range(0, 3)];
      h  = make_hdr(sz, mg);
      gen_pkts(sz, mg, 2, $urandom_range(0, 3), $urandom);
      run_txn(h, $urandom_range(0, 2), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
